uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes (legal 2..8).
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset.
REQ-004 wr_data  input  8  byte to enqueue.
REQ-005 wr_valid  input  1  producer offers wr_data this cycle.
REQ-006 wr_ready  output  1  FIFO can accept; write occurs when wr_valid & wr_ready.
REQ-007 tx_start  output  1  one-cycle start pulse to the downstream serializer.
REQ-008 tx_data  output  8  byte for the serializer; valid while tx_start=1.
REQ-009 tx_busy  input  1  serializer busy; rises the cycle after an accepted tx_start, falls when stop bits end.
REQ-010 level  output  DEPTH_LOG2+1  bytes currently stored.
REQ-011 empty  output  1  level==0.

Function
REQ-012 Storage SHALL be a circular buffer with DEPTH_LOG2-bit write/read pointers that wrap modulo depth without skipping entries.
REQ-013 wr_ready SHALL equal (level != depth), from registered state only; no write when full, even if a pop occurs that cycle.
REQ-014 Simultaneous write and pop SHALL leave level unchanged and keep both bytes ordered.
REQ-015 No bypass: a byte written into an empty FIFO in cycle N SHALL be available at the head in N+1.
REQ-016 Drain FSM states: IDLE, GUARD, DRAIN.
REQ-017 IDLE: when !empty & !tx_busy, tx_start=1 combinationally, tx_data=head byte, head popped that cycle, next state GUARD; otherwise tx_start=0, stay.
REQ-018 GUARD: tx_start=0; tx_busy ignored; unconditionally -> DRAIN next cycle.
REQ-019 DRAIN: tx_start=0; when tx_busy==0 -> IDLE next cycle.
REQ-020 tx_start SHALL never be asserted in two consecutive cycles, nor outside IDLE.
REQ-021 Write-to-start latency SHALL be 1 cycle: byte accepted in N, tx_start in N+1 if FSM in IDLE and tx_busy==0.
REQ-022 Bytes SHALL be transmitted in write order, each exactly once.
REQ-023 tx_data SHALL be 8'h00 whenever tx_start=0.
REQ-024 level SHALL reflect writes/pops from the previous cycle (registered).

Reset
REQ-025 resetn=0 at a clock edge SHALL clear pointers, level=0, empty=1, wr_ready=1, FSM=IDLE, CR flag=0; tx_start=0 during reset.
REQ-026 Reset mid-transfer SHALL discard all queued bytes; the downstream byte in flight is not aborted; the first post-reset start waits for tx_busy==0 (REQ-017).
REQ-027 Storage array contents need no reset.

Configuration
REQ-028 Macro UART_TX_FIFO_CRLF_EN, when defined: if head is 8'h0A and CR flag=0, IDLE SHALL issue tx_start with tx_data=8'h0D without popping and set CR flag; next IDLE start sends 8'h0A, pops, clears CR flag.
REQ-029 CR flag SHALL be internal, cleared by reset; level counts stored bytes only, not inserted CRs.
REQ-030 Macro undefined: 8'h0A is passed unmodified; no CR flag logic is synthesized.

Verification
REQ-031 Bench SHALL model the serializer: tx_busy=1 for 40 cycles starting the cycle after each tx_start.
REQ-032 Single byte: write 8'h55 into empty FIFO at cycle 10 -> tx_start=1, tx_data=8'h55 at cycle 11; next tx_start no earlier than cycle 53.
REQ-033 Fill/full, DEPTH_LOG2=4: 17 back-to-back writes with tx_busy held 1 -> 16 accepted, level=16, wr_ready=0 on 17th; release -> 16 bytes out in order.
REQ-034 Wrap: 40 bytes 8'h00..8'h27 streamed with random wr_valid -> output sequence identical, pointers wrap twice, no loss.
REQ-035 Simultaneous write+pop at level=16 -> write refused; at level=5 -> level stays 5.
REQ-036 Reset at level=7 while tx_busy=1 -> level=0, empty=1 next cycle; new byte 8'hA5 not started until tx_busy falls.
REQ-037 With UART_TX_FIFO_CRLF_EN: write 8'h41,8'h0A -> output 8'h41,8'h0D,8'h0A; without it -> 8'h41,8'h0A.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART serializer through an IDLE/GUARD/DRAIN start handshake.
// Optional macro UART_TX_FIFO_CRLF_EN inserts 8'h0D ahead of every 8'h0A sent.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GUARD,
    ST_DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic [7:0]              mem_q [DEPTH];
  logic [7:0]              head;
  logic                    push;
  logic                    pop;
`ifdef UART_TX_FIFO_CRLF_EN
  logic                    cr_q, cr_d;
`endif

  assign wr_ready = (level_q != FULL_LEVEL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign push     = wr_valid && wr_ready;
  assign head     = mem_q[rd_ptr_q];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    pop      = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
    cr_d     = cr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Gated by resetn so no start is offered while reset is being applied.
        if (resetn && !empty && !tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_GUARD;
`ifdef UART_TX_FIFO_CRLF_EN
          if (head == 8'h0A && !cr_q) begin
            tx_data = 8'h0D;
            cr_d    = 1'b1;
          end else begin
            tx_data = head;
            pop     = 1'b1;
            cr_d    = 1'b0;
          end
`else
          tx_data = head;
          pop     = 1'b1;
`endif
        end
      end
      ST_GUARD: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_q     <= cr_d;
`endif
    end
  end

  // NOTE: storage is left unreset; level and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
